// File: rtl/tensor_matmul_stream_engine.sv
// tensor_matmul_stream_engine: streams A rows one element per cycle against a preloaded B matrix,
// emitting K_DIM accumulated dot products per row on a single-slot backpressured output.
module tensor_matmul_stream_engine #(
  parameter int DATA_W = 8,
  parameter int L_DIM = 4,
  parameter int K_DIM = 4,
  parameter bit SIGNED = 1'b1,
  parameter int ACC_W = 2*DATA_W+$clog2(L_DIM),
  parameter int ROWS_W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             b_wr_en,
  input  logic [$clog2(L_DIM*K_DIM)-1:0]   b_wr_addr,
  input  logic [DATA_W-1:0]                b_wr_data,
  output logic                             b_wr_err,
  input  logic                             start,
  input  logic [ROWS_W-1:0]                num_rows,
  output logic                             busy,
  output logic                             done,
  input  logic                             a_valid,
  input  logic [DATA_W-1:0]                a_data,
  output logic                             a_ready,
  output logic                             out_valid,
  output logic [K_DIM*ACC_W-1:0]           out_data,
  input  logic                             out_ready
);
  localparam int BA_W = $clog2(L_DIM*K_DIM);
  localparam int LC_W = $clog2(L_DIM);
  localparam int PW = 2*DATA_W;
  localparam int EW = ACC_W > PW ? ACC_W : PW;
  localparam logic [LC_W-1:0] LAST = LC_W'(L_DIM-1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ROWS_W-1:0] rows_q, rows_d;
  logic [LC_W-1:0] lcnt_q, lcnt_d;
  logic [DATA_W-1:0] b_q [L_DIM][K_DIM];
  logic [ACC_W-1:0] acc_q [K_DIM];
  logic [ACC_W-1:0] acc_d [K_DIM];
  logic [ACC_W-1:0] res_q [K_DIM];
  logic [ACC_W-1:0] res_d [K_DIM];
  logic [ACC_W-1:0] sum [K_DIM];
  logic out_valid_q, out_valid_d, done_q, done_d, err_q, err_d;
  logic go, a_hs, last, out_hs;
  assign go = start && state_q == IDLE;
  assign a_hs = a_valid && a_ready;
  assign last = a_hs && lcnt_q == LAST;
  assign out_hs = out_valid_q && out_ready;
  // Products are formed at full precision, extended per SIGNED, then wrapped to ACC_W.
  for (genvar k = 0; k < K_DIM; k++) begin : g_lane
    logic [PW-1:0] p;
    logic [EW-1:0] x;
    if (SIGNED) begin : g_s
      assign p = $signed(PW'($signed(a_data))) * $signed(PW'($signed(b_q[lcnt_q][k])));
      assign x = EW'($signed(p));
    end else begin : g_u
      assign p = PW'(a_data) * PW'(b_q[lcnt_q][k]);
      assign x = EW'(p);
    end
    assign sum[k] = (lcnt_q == '0 ? '0 : acc_q[k]) + x[ACC_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = go && num_rows != '0 ? RUN : IDLE;
      RUN: state_d = last && rows_q == ROWS_W'(1) ? DRAIN : RUN;
      DRAIN: state_d = out_hs ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // The last element of a row stalls only while the previous result is still unconsumed.
  always_comb begin
    busy = state_q != IDLE;
    a_ready = state_q == RUN && !(lcnt_q == LAST && out_valid_q && !out_ready);
    out_valid = out_valid_q;
    done = done_q;
    b_wr_err = err_q;
    out_data = '0;
    for (int i = 0; i < K_DIM; i++) out_data[i*ACC_W +: ACC_W] = res_q[i];
  end
  always_comb begin
    rows_d = go ? num_rows : last ? rows_q - ROWS_W'(1) : rows_q;
    lcnt_d = go ? '0 : a_hs ? (lcnt_q == LAST ? '0 : lcnt_q + LC_W'(1)) : lcnt_q;
    out_valid_d = last || (out_valid_q && !out_ready);
    done_d = (go && num_rows == '0) || (state_q == DRAIN && out_hs);
    err_d = b_wr_en && state_q != IDLE;
    for (int i = 0; i < K_DIM; i++) begin
      acc_d[i] = a_hs ? sum[i] : acc_q[i];
      res_d[i] = last ? sum[i] : res_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_q <= '0;
      lcnt_q <= '0;
      out_valid_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      for (int i = 0; i < K_DIM; i++) begin
        acc_q[i] <= '0;
        res_q[i] <= '0;
      end
      for (int l = 0; l < L_DIM; l++)
        for (int i = 0; i < K_DIM; i++) b_q[l][i] <= '0;
    end else begin
      rows_q <= rows_d;
      lcnt_q <= lcnt_d;
      out_valid_q <= out_valid_d;
      done_q <= done_d;
      err_q <= err_d;
      for (int i = 0; i < K_DIM; i++) begin
        acc_q[i] <= acc_d[i];
        res_q[i] <= res_d[i];
      end
      for (int l = 0; l < L_DIM; l++)
        for (int i = 0; i < K_DIM; i++)
          if (b_wr_en && state_q == IDLE && b_wr_addr == BA_W'(l*K_DIM+i)) b_q[l][i] <= b_wr_data;
    end
  end
endmodule

// File: tb/tb_tensor_matmul_stream_engine.sv
// tb_tensor_matmul_stream_engine: directed vectors with a queue scoreboard popped by an output monitor.
module tb_tensor_matmul_stream_engine;
  localparam int AW = 18;
  localparam int VW = 4*AW;
  logic clk = 0, rst_n = 0;
  logic b_wr_en = 0;
  logic [3:0] b_wr_addr = 0;
  logic [7:0] b_wr_data = 0;
  logic start = 0, start_u = 0;
  logic [15:0] num_rows = 0;
  logic a_valid = 0;
  logic [7:0] a_data = 0;
  logic out_ready = 0;
  logic b_wr_err, busy, done, a_ready, out_valid;
  logic [VW-1:0] out_data;
  logic b_wr_err_u, busy_u, done_u, a_ready_u, out_valid_u;
  logic [VW-1:0] out_data_u;
  logic [VW-1:0] q[$];
  logic [VW-1:0] qu[$];
  int errs = 0, checks = 0, dones = 0, dones_u = 0, stalls = 0;
  int d0, s0;

  always #5 clk = ~clk;

  tensor_matmul_stream_engine dut (
    .clk(clk), .rst_n(rst_n), .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .b_wr_err(b_wr_err), .start(start), .num_rows(num_rows), .busy(busy), .done(done),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready));

  tensor_matmul_stream_engine #(.SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .b_wr_err(b_wr_err_u), .start(start_u), .num_rows(num_rows), .busy(busy_u), .done(done_u),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready_u), .out_valid(out_valid_u),
    .out_data(out_data_u), .out_ready(out_ready));

  function automatic logic [VW-1:0] pk(input int a, input int b, input int c, input int d);
    return {AW'(d), AW'(c), AW'(b), AW'(a)};
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [VW-1:0] e;
    if (rst_n) begin
      if (done) dones++;
      if (done_u) dones_u++;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL out_vec: unexpected vector %0h", out_data);
        end else begin
          e = q.pop_front();
          if (out_data !== e) begin
            errs++;
            $display("FAIL out_vec: got %0h expected %0h", out_data, e);
          end
        end
      end
      if (out_valid_u && out_ready) begin
        checks++;
        if (qu.size() == 0) begin
          errs++;
          $display("FAIL out_vec_u: unexpected vector %0h", out_data_u);
        end else begin
          e = qu.pop_front();
          if (out_data_u !== e) begin
            errs++;
            $display("FAIL out_vec_u: got %0h expected %0h", out_data_u, e);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_b(input int addr, input int data);
    b_wr_en = 1; b_wr_addr = 4'(addr); b_wr_data = 8'(data);
    tick;
    b_wr_en = 0;
  endtask

  task automatic load_b(input bit ident, input int v);
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 4; k++) wr_b(l*4+k, ident ? int'(l == k) : v);
  endtask

  task automatic run(input int n, input bit u);
    start = 1; start_u = u; num_rows = 16'(n);
    tick;
    start = 0; start_u = 0;
  endtask

  task automatic push_a(input int d);
    int n = 0;
    a_valid = 1; a_data = 8'(d);
    @(negedge clk);
    while (!a_ready && n < 100) begin
      stalls++; n++;
      @(negedge clk);
    end
    if (!a_ready) begin
      checks++; errs++;
      $display("FAIL a_ready_timeout: got 0 required 1");
    end
    @(posedge clk); #1;
    a_valid = 0;
  endtask

  task automatic row(input int a, input int b, input int c, input int d);
    push_a(a); push_a(b); push_a(c); push_a(d);
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((busy || busy_u) && n < 200) begin
      tick; n++;
    end
    chk("idle", VW'(busy), 0);
    tick;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_busy"}, VW'(busy), 0);
    chk({nm, "_done"}, VW'(done), 0);
    chk({nm, "_aready"}, VW'(a_ready), 0);
    chk({nm, "_ovalid"}, VW'(out_valid), 0);
    chk({nm, "_err"}, VW'(b_wr_err), 0);
    chk({nm, "_odata"}, out_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick; tick;
    chk_reset("rst");
    rst_n = 1;
    tick;
    // Identity B: output equals the A row, valid right after the last element
    load_b(1, 0);
    out_ready = 1;
    d0 = dones;
    q.push_back(pk(3, -2, 7, 5));
    run(1, 0);
    row(3, -2, 7, 5);
    chk("id_lat_valid", VW'(out_valid), 1);
    chk("id_lat_data", out_data, pk(3, -2, 7, 5));
    wait_idle;
    chk("id_done", VW'(dones - d0), 1);
    // Constant B, two back-to-back rows with no stalls
    load_b(0, 2);
    d0 = dones; s0 = stalls;
    q.push_back(pk(20, 20, 20, 20));
    q.push_back(pk(2, 2, 2, 2));
    run(2, 0);
    row(1, 2, 3, 4);
    row(0, 0, 0, 1);
    wait_idle;
    chk("const_stalls", VW'(stalls - s0), 0);
    chk("const_done", VW'(dones - d0), 1);
    // Backpressure: three rows with out_ready pulsed
    load_b(1, 0);
    out_ready = 0;
    d0 = dones;
    q.push_back(pk(1, 2, 3, 4));
    q.push_back(pk(5, 6, 7, 8));
    q.push_back(pk(9, 10, 11, 12));
    run(3, 0);
    fork
      begin
        row(1, 2, 3, 4); row(5, 6, 7, 8); row(9, 10, 11, 12);
      end
      begin
        int n = 0;
        while (!out_valid && n < 50) begin tick; n++; end
        repeat (6) tick;
        chk("bp_hold_valid", VW'(out_valid), 1);
        chk("bp_hold_data", out_data, pk(1, 2, 3, 4));
        chk("bp_aready_low", VW'(a_ready), 0);
        for (int r = 0; r < 3; r++) begin
          out_ready = 1; tick; out_ready = 0;
          repeat (6) tick;
        end
      end
    join
    out_ready = 1;
    wait_idle;
    chk("bp_done", VW'(dones - d0), 1);
    chk("bp_q_empty", VW'(q.size()), 0);
    // Signed extremes, then unsigned max on the SIGNED=0 instance
    load_b(0, -128);
    q.push_back(pk(65536, 65536, 65536, 65536));
    run(1, 0);
    row(-128, -128, -128, -128);
    wait_idle;
    load_b(0, 255);
    q.push_back(pk(4, 4, 4, 4));
    qu.push_back(pk(260100, 260100, 260100, 260100));
    d0 = dones_u;
    run(1, 1);
    row(255, 255, 255, 255);
    wait_idle;
    chk("u_q_empty", VW'(qu.size()), 0);
    chk("u_done", VW'(dones_u - d0), 1);
    chk("u_aready_idle", VW'(a_ready_u), 0);
    // B write while busy is rejected and leaves B intact
    load_b(1, 0);
    q.push_back(pk(1, 2, 3, 4));
    run(1, 0);
    push_a(1); push_a(2);
    wr_b(0, 9);
    chk("werr_pulse", VW'(b_wr_err), 1);
    chk("werr_u_idle", VW'(b_wr_err_u), 0);
    tick;
    chk("werr_clear", VW'(b_wr_err), 0);
    push_a(3); push_a(4);
    wait_idle;
    // Zero-row start: immediate done, no result
    d0 = dones;
    run(0, 0);
    chk("zero_done", VW'(done), 1);
    chk("zero_busy", VW'(busy), 0);
    tick;
    chk("zero_done_clr", VW'(done), 0);
    chk("zero_no_valid", VW'(out_valid), 0);
    chk("zero_done_cnt", VW'(dones - d0), 1);
    // Reset mid-row clears everything including B
    load_b(0, 1);
    d0 = dones;
    run(1, 0);
    push_a(1); push_a(2);
    rst_n = 0;
    tick;
    chk_reset("midrst");
    rst_n = 1;
    tick;
    chk("midrst_no_done", VW'(dones - d0), 0);
    q.push_back(pk(0, 0, 0, 0));
    run(1, 0);
    row(5, 5, 5, 5);
    wait_idle;
    load_b(1, 0);
    q.push_back(pk(4, 3, 2, 1));
    run(1, 0);
    row(4, 3, 2, 1);
    wait_idle;
    chk("final_q_empty", VW'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
